// File: rtl/seg7_monitor.sv
// Receiver-side monitor for an active-low 7-segment bus: stability filter,
// pattern decode, counter-sequence check and saturating error counter.
module seg7_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       seg,
    input  logic             clr_err,
    output logic [3:0]       value,
    output logic             valid,
    output logic             new_val,
    output logic             blank,
    output logic             code_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [6:0]       SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [6:0]       r_cand;
    logic [6:0]       r_acc_pat;
    logic [RUN_W-1:0] r_run;
    logic [3:0]       r_value;
    logic             r_valid;
    logic             r_new_val;
    logic             r_blank;
    logic             r_code_err;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_count;

    logic             w_match;
    logic [RUN_W-1:0] w_run_base;
    logic [RUN_W-1:0] w_run_next;
    logic             w_accept;
    logic             w_legal;
    logic             w_is_blank;
    logic [3:0]       w_dec;
    logic             w_new_val_next;
    logic             w_code_err_next;
    logic             w_seq_err_next;
    logic             w_err_inc;
    logic [ERR_W-1:0] w_err_next;

    // A changed pattern starts a fresh run from zero, so with a window of 1
    // it is accepted on its very first edge.
    always_comb begin
        w_match    = (seg == r_cand);
        w_run_base = w_match ? r_run : '0;
        w_run_next = (w_run_base == RUN_MAX) ? RUN_MAX : w_run_base + 1'b1;
        w_accept   = (w_run_next == RUN_MAX) && (w_run_base < RUN_MAX) &&
                     ((r_state == ST_EMPTY) || (seg != r_acc_pat));
    end

    always_comb begin
        w_legal    = 1'b1;
        w_is_blank = 1'b0;
        w_dec      = 4'h0;
        case (seg)
            7'h40:   w_dec = 4'h0;
            7'h79:   w_dec = 4'h1;
            7'h24:   w_dec = 4'h2;
            7'h30:   w_dec = 4'h3;
            7'h19:   w_dec = 4'h4;
            7'h12:   w_dec = 4'h5;
            7'h02:   w_dec = 4'h6;
            7'h78:   w_dec = 4'h7;
            7'h00:   w_dec = 4'h8;
            7'h10:   w_dec = 4'h9;
            7'h08:   w_dec = 4'hA;
            7'h03:   w_dec = 4'hB;
            7'h46:   w_dec = 4'hC;
            7'h21:   w_dec = 4'hD;
            7'h06:   w_dec = 4'hE;
            7'h0E:   w_dec = 4'hF;
            SEG_OFF: begin
                w_legal    = 1'b0;
                w_is_blank = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next    = w_accept ? ST_LOCKED : r_state;
        w_new_val_next  = w_accept && w_legal;
        w_code_err_next = w_accept && !w_legal && !w_is_blank;
        w_seq_err_next  = w_accept && w_legal && r_valid && (w_dec != r_value + 4'd1);
        w_err_inc       = w_code_err_next || w_seq_err_next;
        w_err_next      = r_err_count;
        if (clr_err)
            w_err_next = w_err_inc ? ERR_W'(1) : '0;
        else if (w_err_inc && (r_err_count != {ERR_W{1'b1}}))
            w_err_next = r_err_count + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand      <= SEG_OFF;
            r_run       <= '0;
            r_acc_pat   <= SEG_OFF;
            r_value     <= 4'h0;
            r_valid     <= 1'b0;
            r_new_val   <= 1'b0;
            r_blank     <= 1'b0;
            r_code_err  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_cand      <= seg;
            r_run       <= w_run_next;
            r_new_val   <= w_new_val_next;
            r_code_err  <= w_code_err_next;
            r_seq_err   <= w_seq_err_next;
            r_err_count <= w_err_next;
            if (w_accept) begin
                r_acc_pat <= seg;
                // Illegal patterns leave value/valid/blank untouched.
                if (w_legal) begin
                    r_value <= w_dec;
                    r_valid <= 1'b1;
                    r_blank <= 1'b0;
                end else if (w_is_blank) begin
                    r_valid <= 1'b0;
                    r_blank <= 1'b1;
                end
            end
        end
    end

    assign value     = r_value;
    assign valid     = r_valid;
    assign new_val   = r_new_val;
    assign blank     = r_blank;
    assign code_err  = r_code_err;
    assign seq_err   = r_seq_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor: default instance (window 4, 8-bit count)
// plus a window-1 / 2-bit-count instance for saturation and clear tests.
module tb_seg7_monitor;

    localparam logic [6:0] SEGS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ILL   = 7'h2A;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] seg;
    logic       clr_err;
    logic [3:0] value;
    logic       valid, new_val, blank, code_err, seq_err;
    logic [7:0] err_count;

    logic       rst2_n;
    logic [6:0] seg2;
    logic       clr2;
    logic [3:0] value2;
    logic       valid2, new_val2, blank2, code_err2, seq_err2;
    logic [1:0] err_count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_monitor #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .seg(seg), .clr_err(clr_err),
        .value(value), .valid(valid), .new_val(new_val), .blank(blank),
        .code_err(code_err), .seq_err(seq_err), .err_count(err_count)
    );

    seg7_monitor #(.STABLE_CYCLES(1), .ERR_W(2)) dut2 (
        .clk(clk), .reset_n(rst2_n), .seg(seg2), .clr_err(clr2),
        .value(value2), .valid(valid2), .new_val(new_val2), .blank(blank2),
        .code_err(code_err2), .seq_err(seq_err2), .err_count(err_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [6:0] pat);
        @(negedge clk);
        seg = pat;
        @(posedge clk);
        #1;
    endtask

    task automatic tick2(input logic [6:0] pat, input logic clr);
        @(negedge clk);
        seg2 = pat;
        clr2 = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag, input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            tick(pat);
            check({tag, ".nv"}, 32'(new_val), 0);
            check({tag, ".ce"}, 32'(code_err), 0);
            check({tag, ".se"}, 32'(seq_err), 0);
        end
    endtask

    task automatic expect_accept(input string tag, input logic [6:0] pat,
                                 input logic nv, input logic ce, input logic se);
        quiet({tag, ".pre"}, pat, 3);
        tick(pat);
        check({tag, ".nv"}, 32'(new_val), 32'(nv));
        check({tag, ".ce"}, 32'(code_err), 32'(ce));
        check({tag, ".se"}, 32'(seq_err), 32'(se));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        rst2_n  = 1'b0;
        seg     = SEGS[0];
        seg2    = SEGS[0];
        clr_err = 1'b0;
        clr2    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.value", 32'(value), 0);
        check("rst.valid", 32'(valid), 0);
        check("rst.new_val", 32'(new_val), 0);
        check("rst.blank", 32'(blank), 0);
        check("rst.code_err", 32'(code_err), 0);
        check("rst.seq_err", 32'(seq_err), 0);
        check("rst.err_count", 32'(err_count), 0);
        reset_n = 1'b1;

        // 1: full count 0..F then wrap to 0
        for (int v = 0; v < 17; v++) begin
            expect_accept($sformatf("t1.v%0d", v), SEGS[v % 16], 1'b1, 1'b0, 1'b0);
            check($sformatf("t1.value%0d", v), 32'(value), 32'(v % 16));
            check($sformatf("t1.valid%0d", v), 32'(valid), 1);
        end
        check("t1.err_count", 32'(err_count), 0);

        // 2: blank, then 3 with glitch that returns to 3
        expect_accept("t2.blank", SEG_BLANK, 1'b0, 1'b0, 1'b0);
        check("t2.blank_valid", 32'(valid), 0);
        check("t2.blank_flag", 32'(blank), 1);
        check("t2.blank_value", 32'(value), 0);
        expect_accept("t2.three", SEGS[3], 1'b1, 1'b0, 1'b0);
        quiet("t2.hold", SEGS[3], 2);
        quiet("t2.glitch", SEGS[8], 2);
        quiet("t2.back", SEGS[3], 6);
        check("t2.value", 32'(value), 3);
        check("t2.blank_clr", 32'(blank), 0);
        check("t2.err_count", 32'(err_count), 0);

        // 3: 3,4,5 then jump to 7
        expect_accept("t3.four", SEGS[4], 1'b1, 1'b0, 1'b0);
        expect_accept("t3.five", SEGS[5], 1'b1, 1'b0, 1'b0);
        check("t3.value5", 32'(value), 5);
        expect_accept("t3.seven", SEGS[7], 1'b1, 1'b0, 1'b1);
        check("t3.value7", 32'(value), 7);
        check("t3.err_count", 32'(err_count), 1);

        // 4: illegal, blank, then 9 without sequence check
        expect_accept("t4.ill", SEG_ILL, 1'b0, 1'b1, 1'b0);
        check("t4.ill_value", 32'(value), 7);
        check("t4.ill_valid", 32'(valid), 1);
        check("t4.err_count", 32'(err_count), 2);
        expect_accept("t4.blank", SEG_BLANK, 1'b0, 1'b0, 1'b0);
        check("t4.blank_valid", 32'(valid), 0);
        check("t4.blank_flag", 32'(blank), 1);
        expect_accept("t4.nine", SEGS[9], 1'b1, 1'b0, 1'b0);
        check("t4.nine_value", 32'(value), 9);
        check("t4.nine_valid", 32'(valid), 1);
        check("t4.nine_blank", 32'(blank), 0);
        check("t4.err_count2", 32'(err_count), 2);

        // 5: window 1, 2-bit saturating counter and clear
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        tick2(SEGS[0], 1'b0);
        check("t5.first_nv", 32'(new_val2), 1);
        check("t5.first_se", 32'(seq_err2), 0);
        check("t5.first_cnt", 32'(err_count2), 0);
        tick2(SEGS[2], 1'b0);
        check("t5.e1_se", 32'(seq_err2), 1);
        check("t5.e1_cnt", 32'(err_count2), 1);
        tick2(SEGS[4], 1'b0);
        check("t5.e2_cnt", 32'(err_count2), 2);
        tick2(SEGS[6], 1'b0);
        check("t5.e3_cnt", 32'(err_count2), 3);
        tick2(SEGS[8], 1'b0);
        check("t5.e4_se", 32'(seq_err2), 1);
        check("t5.e4_cnt", 32'(err_count2), 3);
        tick2(SEG_ILL, 1'b0);
        check("t5.e5_ce", 32'(code_err2), 1);
        check("t5.e5_se", 32'(seq_err2), 0);
        check("t5.e5_cnt", 32'(err_count2), 3);
        check("t5.e5_value", 32'(value2), 8);
        tick2(SEG_ILL, 1'b1);
        check("t5.clr_ce", 32'(code_err2), 0);
        check("t5.clr_cnt", 32'(err_count2), 0);
        tick2(SEGS[11], 1'b1);
        check("t5.clrse_se", 32'(seq_err2), 1);
        check("t5.clrse_cnt", 32'(err_count2), 1);
        check("t5.clrse_value", 32'(value2), 11);
        tick2(SEGS[12], 1'b0);
        check("t5.next_nv", 32'(new_val2), 1);
        check("t5.next_se", 32'(seq_err2), 0);
        check("t5.next_cnt", 32'(err_count2), 1);

        // 6: asynchronous reset in the middle of a run of 4
        quiet("t6.run", SEGS[4], 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6.value", 32'(value), 0);
        check("t6.valid", 32'(valid), 0);
        check("t6.blank", 32'(blank), 0);
        check("t6.new_val", 32'(new_val), 0);
        check("t6.code_err", 32'(code_err), 0);
        check("t6.seq_err", 32'(seq_err), 0);
        check("t6.err_count", 32'(err_count), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_accept("t6.four", SEGS[4], 1'b1, 1'b0, 1'b0);
        check("t6.four_value", 32'(value), 4);
        check("t6.four_valid", 32'(valid), 1);
        check("t6.four_cnt", 32'(err_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_monitor.md
Name: seg7_monitor

Overview:
- Receiver-side companion to the 4-bit counter / 7-segment encoder path.
- Samples a 7-segment drive bus, filters glitches with a stability window, and decodes the pattern back to a 4-bit value.
- Checks that successive values follow the counter sequence n -> n+1 mod 16 and flags illegal patterns and sequence breaks.
- Used as an in-design self-check on the display output and as a bench monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive sampled edges a pattern must hold before it is accepted (legal range >= 1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- seg  input  7  display bus; seg[6:0] = g,f,e,d,c,b,a; active-low (0 = segment lit).
- clr_err  input  1  synchronous clear of err_count.
- value  output  4  last accepted legal decoded value.
- valid  output  1  value is meaningful.
- new_val  output  1  one-cycle strobe: a legal value was accepted this cycle.
- blank  output  1  last accepted pattern was all segments off.
- code_err  output  1  one-cycle strobe: accepted pattern is illegal.
- seq_err  output  1  one-cycle strobe: accepted legal value is not previous+1 mod 16.
- err_count  output  ERR_W  saturating count of code_err plus seq_err events.

Behaviour:
- Reset (async, reset_n=0):
  - value=0, valid=0, new_val=0, blank=0, code_err=0, seq_err=0, err_count=0.
  - Internal: cand=7'h7F, run=0, acc_pat=7'h7F, state=EMPTY.
  - Reset asserted mid-run discards the partial run immediately.
- Stability filter, evaluated each edge:
  - If seg==cand: run_next = min(run+1, STABLE_CYCLES).
  - Otherwise: cand<=seg and run_next=1.
  - Accept when run_next==STABLE_CYCLES and run<STABLE_CYCLES, and either state==EMPTY or cand_next!=acc_pat.
  - Pattern P held on edges k..k+S-1 is accepted at edge k+S-1; outputs are registered and visible after that edge.
  - Only one acceptance per run. A glitch that returns to the already-accepted pattern causes no new acceptance.
  - With STABLE_CYCLES=1, acceptance happens on the first edge of a changed pattern.
- Decode table (seg[6:0] -> value):
  - 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001  5:0010010  6:0000010  7:1111000
  - 8:0000000  9:0010000  A:0001000  b:0000011  C:1000110  d:0100001  E:0000110  F:0001110
  - 1111111 is blank. Any other pattern is illegal.
- On acceptance (acc_pat<=pattern, state<=LOCKED):
  - Legal pattern:
    - value<=decoded, valid<=1, blank<=0, new_val=1 for one cycle.
    - If valid was 1 before the update and decoded != (value+1) mod 16, seq_err=1 for one cycle.
    - 15 -> 0 is legal and raises no error.
    - If valid was 0 (first value after reset, or first after a blank), no sequence check.
  - Blank: valid<=0, blank<=1, value held. No strobe, no error.
  - Illegal: code_err=1 for one cycle; value, valid and blank held. No sequence check on the next legal value if valid is 0.
- Strobes new_val, code_err and seq_err are 0 in every cycle without acceptance.
- code_err and seq_err are mutually exclusive.
- err_count:
  - +1 per error strobe, saturating at all-ones with no wrap.
  - clr_err alone -> 0.
  - clr_err in the same cycle as an error strobe -> 1.
- FSM:
  - EMPTY -> LOCKED on first acceptance.
  - LOCKED -> EMPTY only by reset.

Test Plan:
1. Reset, then drive 0..F encodings, each held 4 cycles, then 0 again -> value follows 0..F,0; new_val pulses 17 times, each at the 4th held edge; seq_err=0, err_count=0.
2. Hold 3 (0110000) 6 cycles, glitch to 0000000 for 2 cycles, return to 0110000 -> single acceptance of 3; no new_val, no err.
3. With valid value 5, drive 7 (1111000) for 4 cycles -> value=7, new_val=1 and seq_err=1 same cycle, err_count=1.
4. Drive illegal 0101010 for 4 cycles -> code_err pulse, value held, err_count+1; then blank 1111111 -> valid=0, blank=1; then 9 -> valid=1, value=9, no seq_err.
5. ERR_W=2: force 5 errors -> err_count sticks at 3; assert clr_err coincident with a seq_err -> err_count=1.
6. Assert reset_n=0 two cycles into a 4-cycle run of 4 (0011001) -> all outputs 0 asynchronously; after release the pattern needs 4 fresh edges and is accepted with no seq check.
